// File: rtl/instr_seq_ctrl_pkg.sv
// instr_seq_ctrl_pkg: opcodes, FSM states and opcode-class helpers; S_PAUSE exists only with SEQ_STEP_EN
package instr_seq_ctrl_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDZ = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b0110;
  localparam logic [3:0] OP_SHL  = 4'b0111;
  localparam logic [3:0] OP_MOV  = 4'b1010;
  localparam logic [3:0] OP_LDI  = 4'b1011;
  localparam logic [3:0] OP_HLT  = 4'b1111;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
`ifdef SEQ_STEP_EN
    , S_PAUSE
`endif
  } state_t;
  function automatic logic reads_p0(input logic [3:0] op);
    return op <= OP_SHL || op == OP_MOV;
  endfunction
  function automatic logic reads_p1(input logic [3:0] op);
    return op <= OP_OR;
  endfunction
  function automatic logic writes_reg(input logic [3:0] op);
    return op == OP_ADD || (op >= OP_SUB && op <= OP_SHL) || op == OP_MOV || op == OP_LDI;
  endfunction
  function automatic logic is_illegal(input logic [3:0] op);
    return op == 4'b1000 || op == 4'b1001 || (op >= 4'b1100 && op <= 4'b1110);
  endfunction
endpackage

// File: rtl/instr_seq_ctrl_if.sv
// instr_seq_ctrl_if: imem handshake, decoder/datapath strobes and status; step port only with SEQ_STEP_EN
interface instr_seq_ctrl_if #(parameter int PC_W = 16);
  logic imem_rdy;
  logic [15:0] imem_data;
  logic zr;
`ifdef SEQ_STEP_EN
  logic step;
`endif
  logic imem_re;
  logic [PC_W-1:0] pc;
  logic [15:0] ir;
  logic re0, re1, alu_go, we, hlt, fetch_err, ill_op;
  modport master(
    input imem_rdy, imem_data, zr,
`ifdef SEQ_STEP_EN
    input step,
`endif
    output imem_re, pc, ir, re0, re1, alu_go, we, hlt, fetch_err, ill_op
  );
  modport slave(
    output imem_rdy, imem_data, zr,
`ifdef SEQ_STEP_EN
    output step,
`endif
    input imem_re, pc, ir, re0, re1, alu_go, we, hlt, fetch_err, ill_op
  );
endinterface

// File: rtl/instr_seq_ctrl_fetch_timer.sv
// instr_seq_ctrl_fetch_timer: counts unanswered fetch cycles and flags the last allowed one
module instr_seq_ctrl_fetch_timer #(parameter int FETCH_TO = 15) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [7:0] cnt;
  // clear wins over enable; holds otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 8'd1 : cnt;
  assign timeout = cnt == 8'(FETCH_TO - 1);
endmodule

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: multi-cycle fetch/decode/exec/wb sequencer; SEQ_STEP_EN adds single-step PAUSE state
module instr_seq_ctrl
  import instr_seq_ctrl_pkg::*;
#(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int FETCH_TO = 15
) (
  input logic clk,
  input logic rst,
  instr_seq_ctrl_if.master bus
);
  state_t state;
  logic [PC_W-1:0] pc;
  logic [15:0] ir;
  logic imem_re, re0, re1, alu_go, we, hlt, fetch_err, ill_op, zr_q, timeout, waiting;
  logic [3:0] op, d_op;
  assign op = ir[15:12];
  assign d_op = bus.imem_data[15:12];
  assign waiting = state == S_FETCH && !bus.imem_rdy;
  instr_seq_ctrl_fetch_timer #(.FETCH_TO(FETCH_TO)) u_timer (
    .clk(clk), .rst(rst), .clr(!waiting), .en(waiting), .timeout(timeout)
  );
  // phase FSM; every strobe is registered and set on entry to the phase that owns it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      zr_q      <= 1'b0;
      imem_re   <= 1'b1;
      re0       <= 1'b0;
      re1       <= 1'b0;
      alu_go    <= 1'b0;
      we        <= 1'b0;
      ill_op    <= 1'b0;
      hlt       <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      imem_re <= 1'b0;
      re0     <= 1'b0;
      re1     <= 1'b0;
      alu_go  <= 1'b0;
      we      <= 1'b0;
      ill_op  <= 1'b0;
      case (state)
        S_FETCH:
          if (bus.imem_rdy) begin
            ir    <= bus.imem_data;
            re0   <= reads_p0(d_op);
            re1   <= reads_p1(d_op);
            state <= S_DECODE;
          end else if (timeout) begin
            fetch_err <= 1'b1;
            hlt       <= 1'b1;
            state     <= S_HALT;
          end else imem_re <= 1'b1;
        S_DECODE: begin
          zr_q <= bus.zr;
          if (op == OP_HLT) begin
            hlt   <= 1'b1;
            state <= S_HALT;
          end else begin
            alu_go <= 1'b1;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          we     <= writes_reg(op) || (op == OP_ADDZ && zr_q);
          ill_op <= is_illegal(op);
          state  <= S_WB;
        end
        S_WB: begin
          pc <= pc + PC_W'(1);
`ifdef SEQ_STEP_EN
          state <= S_PAUSE;
`else
          imem_re <= 1'b1;
          state   <= S_FETCH;
`endif
        end
`ifdef SEQ_STEP_EN
        S_PAUSE:
          if (bus.step) begin
            imem_re <= 1'b1;
            state   <= S_FETCH;
          end
`endif
        default: state <= S_HALT;
      endcase
    end
  assign bus.imem_re   = imem_re;
  assign bus.pc        = pc;
  assign bus.ir        = ir;
  assign bus.re0       = re0;
  assign bus.re1       = re1;
  assign bus.alu_go    = alu_go;
  assign bus.we        = we;
  assign bus.hlt       = hlt;
  assign bus.fetch_err = fetch_err;
  assign bus.ill_op    = ill_op;
endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl: scoreboard bench with random instruction stream plus directed timing/boundary checks
module tb_instr_seq_ctrl;
`ifdef SEQ_STEP_EN
  localparam int CPI = 5;
`else
  localparam int CPI = 4;
`endif
  typedef struct {
    logic [15:0] pc;
    logic [15:0] word;
    logic re0, re1, we, ill;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  exp_t q[$];
  exp_t cur;
  logic mon_on = 1'b0;
  logic pend, p0, p1, bad;
  logic [15:0] pc_m, word;
  logic [3:0] op4;
  logic z;
  always #5 clk = ~clk;
  instr_seq_ctrl_if #(.PC_W(16)) m_if();
  instr_seq_ctrl_if #(.PC_W(16)) w_if();
  instr_seq_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .FETCH_TO(15)) dut (
    .clk(clk), .rst(rst), .bus(m_if.master)
  );
  instr_seq_ctrl #(.PC_W(16), .RESET_PC(16'hFFFF), .FETCH_TO(15)) u_wrap (
    .clk(clk), .rst(rst), .bus(w_if.master)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [15:0] pc, input logic [15:0] w, input logic zv);
    exp_t e;
    int op;
    op = int'(w[15:12]);
    e.pc = pc;
    e.word = w;
    e.re0 = op < 8 || op == 10;
    e.re1 = op < 5;
    e.ill = op inside {8, 9, 12, 13, 14};
    e.we = (op == 1) ? zv : (!e.ill && op != 15);
    return e;
  endfunction
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic issue(input logic [15:0] w, input logic zv, input int waits);
    int n = 0;
    while (m_if.imem_re !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch request", 32'(m_if.imem_re), 1);
    m_if.zr = zv;
    repeat (waits) begin
      m_if.imem_rdy = 1'b0;
      m_if.imem_data = 16'($urandom);
      @(negedge clk);
    end
    m_if.imem_rdy = 1'b1;
    m_if.imem_data = w;
    @(negedge clk);
    m_if.imem_rdy = 1'($urandom_range(0, 1));
    m_if.imem_data = 16'($urandom);
  endtask
  // monitor: phase exclusivity every cycle, then per-instruction compare against the queued expectation
  initial begin
    pend = 1'b0;
    p0 = 1'b0;
    p1 = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on && !rst) begin
        if (m_if.re0 || m_if.re1 || m_if.alu_go || m_if.we || m_if.ill_op)
          chk("strobe overlap", 32'(int'(m_if.re0 | m_if.re1) + int'(m_if.alu_go) + int'(m_if.we | m_if.ill_op)), 1);
        if (pend) begin
          chk("wb we", 32'(m_if.we), 32'(cur.we));
          chk("wb ill_op", 32'(m_if.ill_op), 32'(cur.ill));
          pend = 1'b0;
        end
        if (m_if.alu_go) begin
          if (q.size() == 0) chk("unexpected alu_go", 1, 0);
          else begin
            cur = q.pop_front();
            chk("decode re0", 32'(p0), 32'(cur.re0));
            chk("decode re1", 32'(p1), 32'(cur.re1));
            chk("exec pc", 32'(m_if.pc), 32'(cur.pc));
            chk("exec ir", 32'(m_if.ir), 32'(cur.word));
            pend = 1'b1;
          end
        end
      end
      p0 = m_if.re0;
      p1 = m_if.re1;
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    m_if.imem_rdy = 1'b0;
    m_if.imem_data = '0;
    m_if.zr = 1'b0;
    w_if.imem_rdy = 1'b0;
    w_if.imem_data = '0;
    w_if.zr = 1'b0;
`ifdef SEQ_STEP_EN
    m_if.step = 1'b1;
    w_if.step = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk("rst pc", 32'(m_if.pc), 0);
    chk("rst ir", 32'(m_if.ir), 0);
    chk("rst imem_re", 32'(m_if.imem_re), 1);
    chk("rst re0", 32'(m_if.re0), 0);
    chk("rst re1", 32'(m_if.re1), 0);
    chk("rst alu_go", 32'(m_if.alu_go), 0);
    chk("rst we", 32'(m_if.we), 0);
    chk("rst hlt", 32'(m_if.hlt), 0);
    chk("rst fetch_err", 32'(m_if.fetch_err), 0);
    chk("rst ill_op", 32'(m_if.ill_op), 0);
    chk("rst wrap pc", 32'(w_if.pc), 32'hFFFF);
    m_if.imem_rdy = 1'b1;
    m_if.imem_data = 16'h0123;
    w_if.imem_rdy = 1'b1;
    w_if.imem_data = 16'h0123;
    rst = 1'b0;
    @(negedge clk);
    chk("lat decode re0", 32'(m_if.re0), 1);
    chk("lat decode re1", 32'(m_if.re1), 1);
    chk("lat decode pc", 32'(m_if.pc), 0);
    chk("lat decode alu_go", 32'(m_if.alu_go), 0);
    @(negedge clk);
    chk("lat exec alu_go", 32'(m_if.alu_go), 1);
    chk("lat exec re0", 32'(m_if.re0), 0);
    @(negedge clk);
    chk("lat wb we", 32'(m_if.we), 1);
    chk("lat wb alu_go", 32'(m_if.alu_go), 0);
    chk("wrap wb we", 32'(w_if.we), 1);
    repeat (CPI - 3) @(negedge clk);
    chk("lat next pc", 32'(m_if.pc), 1);
    chk("lat next imem_re", 32'(m_if.imem_re), 1);
    chk("lat next we", 32'(m_if.we), 0);
    chk("wrap pc", 32'(w_if.pc), 0);
    m_if.imem_rdy = 1'b0;
    w_if.imem_data = 16'hC000;
    repeat (3) @(negedge clk);
    chk("illegal ill_op", 32'(w_if.ill_op), 1);
    chk("illegal we", 32'(w_if.we), 0);
    @(negedge clk);
    chk("illegal ill_op pulse", 32'(w_if.ill_op), 0);
    chk("illegal pc", 32'(w_if.pc), 1);
    w_if.imem_rdy = 1'b0;
    do_reset();
    repeat (14) @(negedge clk);
    chk("timeout early fetch_err", 32'(m_if.fetch_err), 0);
    chk("timeout early imem_re", 32'(m_if.imem_re), 1);
    @(negedge clk);
    chk("timeout fetch_err", 32'(m_if.fetch_err), 1);
    chk("timeout hlt", 32'(m_if.hlt), 1);
    chk("timeout imem_re", 32'(m_if.imem_re), 0);
    repeat (3) @(negedge clk);
    chk("timeout sticky", 32'(m_if.fetch_err), 1);
    do_reset();
    repeat (14) @(negedge clk);
    m_if.imem_rdy = 1'b1;
    m_if.imem_data = 16'h0123;
    @(negedge clk);
    m_if.imem_rdy = 1'b0;
    chk("late rdy fetch_err", 32'(m_if.fetch_err), 0);
    chk("late rdy hlt", 32'(m_if.hlt), 0);
    chk("late rdy re0", 32'(m_if.re0), 1);
`ifdef SEQ_STEP_EN
    m_if.step = 1'b0;
    m_if.imem_rdy = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    m_if.imem_rdy = 1'b0;
    chk("pause imem_re", 32'(m_if.imem_re), 0);
    chk("pause pc", 32'(m_if.pc), 1);
    repeat (5) @(negedge clk);
    chk("pause hold", 32'(m_if.imem_re), 0);
    m_if.step = 1'b1;
    @(negedge clk);
    chk("pause step fetch", 32'(m_if.imem_re), 1);
`endif
    m_if.imem_rdy = 1'b1;
    m_if.imem_data = 16'h0123;
    do_reset();
    repeat (CPI + 2) @(negedge clk);
    chk("mid exec alu_go", 32'(m_if.alu_go), 1);
    chk("mid exec pc", 32'(m_if.pc), 1);
    m_if.imem_rdy = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid rst pc", 32'(m_if.pc), 0);
    chk("mid rst ir", 32'(m_if.ir), 0);
    chk("mid rst alu_go", 32'(m_if.alu_go), 0);
    chk("mid rst imem_re", 32'(m_if.imem_re), 1);
    bad = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bad = bad | m_if.we | m_if.alu_go;
    end
    chk("mid rst no write", 32'(bad), 0);
    chk("mid rst pc after", 32'(m_if.pc), 0);
    do_reset();
    mon_on = 1'b1;
    pc_m = '0;
    for (int i = 0; i < 40; i++) begin
      op4 = (i < 4) ? 4'd1 : 4'($urandom_range(0, 14));
      word = {op4, 12'($urandom)};
      z = (i < 4) ? 1'(i % 2) : 1'($urandom_range(0, 1));
      q.push_back(model(pc_m, word, z));
      issue(word, z, $urandom_range(0, 5));
      pc_m = pc_m + 16'd1;
    end
    issue(16'hF000, 1'b0, 1);
    m_if.imem_rdy = 1'b0;
    @(negedge clk);
    chk("halt hlt", 32'(m_if.hlt), 1);
    chk("halt pc", 32'(m_if.pc), 32'(pc_m));
    chk("halt fetch_err", 32'(m_if.fetch_err), 0);
    for (int n = 0; n < 50 && (q.size() != 0 || pend); n++) @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 0);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      bad = bad | m_if.imem_re | m_if.alu_go | m_if.we;
    end
    chk("halt quiet", 32'(bad), 0);
    chk("halt pc hold", 32'(m_if.pc), 32'(pc_m));
    chk("halt sticky", 32'(m_if.hlt), 1);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
